// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-schedule / keystream sequencer.
package rc4_pkg;

  localparam int SBOX_DEPTH = 256;
  localparam int SBOX_AW    = 8;

  typedef enum logic [3:0] {
    IDLE, INIT, K_RI, K_RJ, K_SW, P_RI, P_RJ, P_SW, P_RK, P_OUT
  } state_t;

endpackage

// File: rtl/rc4_sched_if.sv
// Keystream valid/ready handshake between the sequencer and its consumer.
interface rc4_sched_if;
  logic [7:0] ks_data;
  logic       ks_valid;
  logic       ks_ready;

  modport master (output ks_data, ks_valid, input ks_ready);
  modport slave  (input ks_data, ks_valid, output ks_ready);
endinterface

// File: rtl/rc4_sched.sv
// RC4 sequencer: initialises and key-schedules an external S-box RAM, then
// streams keystream bytes one swap per five cycles over a valid/ready port.
module rc4_sched
  import rc4_pkg::*;
#(
  parameter int SBOX_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         key_len,
  output logic [7:0]         key_addr,
  input  logic [7:0]         key_data,
  output logic [SBOX_AW-1:0] raddr_1,
  input  logic [7:0]         rdata_1,
  output logic [SBOX_AW-1:0] waddr_2,
  output logic [7:0]         wdata_2,
  output logic               wen_2,
  output logic [SBOX_AW-1:0] addr_3,
  output logic [7:0]         wdata_3,
  output logic               wen_3,
  input  logic [7:0]         rdata_3,
  output logic               busy,
  output logic               key_ready,
  rc4_sched_if.master        ks
);

  state_t     state;
  logic [7:0] i, j, kidx, t, si, klen, ks_q;
  logic [7:0] j_new;

  // The RAM has one cycle of read latency, so the new j must reach addr_3
  // in the same cycle it is computed for S[j] to be ready at the swap.
  always_comb j_new = j + rdata_1 + ((state == K_RJ) ? key_data : 8'd0);

  always_comb begin
    raddr_1 = '0;
    waddr_2 = '0;
    wdata_2 = '0;
    wen_2   = 1'b0;
    addr_3  = '0;
    wdata_3 = '0;
    wen_3   = 1'b0;
    case (state)
      INIT: begin
        wen_2   = 1'b1;
        waddr_2 = i;
        wdata_2 = i;
      end
      K_RI:        raddr_1 = i;
      P_RI:        raddr_1 = i + 8'd1;
      K_RJ, P_RJ:  addr_3  = j_new;
      K_SW, P_SW: begin
        wen_2   = 1'b1;
        waddr_2 = i;
        wdata_2 = rdata_3;
        addr_3  = j;
        wdata_3 = si;
        wen_3   = (i != j);
      end
      // Holding t keeps rdata_1 (the output byte) stable while stalled.
      P_RK, P_OUT: raddr_1 = t;
      default: ;
    endcase
    if (abort) begin
      wen_2 = 1'b0;
      wen_3 = 1'b0;
    end
  end

  assign key_addr    = kidx;
  assign busy        = !(state inside {IDLE, P_OUT});
  assign ks.ks_valid = (state == P_OUT);
  assign ks.ks_data  = (state == P_OUT) ? rdata_1 : ks_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      kidx      <= '0;
      t         <= '0;
      si        <= '0;
      klen      <= '0;
      ks_q      <= '0;
      key_ready <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      key_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= INIT;
          i     <= '0;
          j     <= '0;
          kidx  <= '0;
          klen  <= key_len;
        end
        INIT: begin
          i <= i + 8'd1;
          if (i == 8'hFF) state <= K_RI;
        end
        K_RI: state <= K_RJ;
        K_RJ: begin
          si    <= rdata_1;
          j     <= j_new;
          state <= K_SW;
        end
        K_SW: begin
          // 8-bit compare makes key_len 0 wrap after 256 bytes.
          kidx <= (kidx + 8'd1 == klen) ? 8'd0 : kidx + 8'd1;
          i    <= i + 8'd1;
          if (i == 8'hFF) begin
            state     <= P_RI;
            j         <= '0;
            key_ready <= 1'b1;
          end else begin
            state <= K_RI;
          end
        end
        P_RI: begin
          i     <= i + 8'd1;
          state <= P_RJ;
        end
        P_RJ: begin
          si    <= rdata_1;
          j     <= j_new;
          state <= P_SW;
        end
        P_SW: begin
          t     <= si + rdata_3;
          state <= P_RK;
        end
        P_RK: state <= P_OUT;
        P_OUT: begin
          ks_q <= rdata_1;
          if (ks.ks_ready) state <= P_RI;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_sched.sv
// Bench for rc4_sched: behavioural S-box RAM, key ROM and a software RC4 model.
module tb_rc4_sched;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [7:0] key_len, key_addr, key_data;
  logic [7:0] raddr_1, rdata_1, waddr_2, wdata_2, addr_3, wdata_3, rdata_3;
  logic       wen_2, wen_3, busy, key_ready;

  rc4_sched_if ks_if();

  rc4_sched #(.SBOX_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .key_len(key_len), .key_addr(key_addr), .key_data(key_data),
    .raddr_1(raddr_1), .rdata_1(rdata_1),
    .waddr_2(waddr_2), .wdata_2(wdata_2), .wen_2(wen_2),
    .addr_3(addr_3), .wdata_3(wdata_3), .wen_3(wen_3), .rdata_3(rdata_3),
    .busy(busy), .key_ready(key_ready), .ks(ks_if)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] key [256];
  assign key_data = key[key_addr];

  always @(posedge clk) begin
    rdata_1 <= mem[raddr_1];
    rdata_3 <= mem[addr_3];
    if (wen_2) mem[waddr_2] <= wdata_2;
    if (wen_3) mem[addr_3]  <= wdata_3;
  end

  int cyc = 0;
  int collisions = 0;
  always @(posedge clk) begin
    cyc++;
    if (wen_2 && wen_3 && waddr_2 == addr_3) collisions++;
  end

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];

  logic [7:0] kv_key[10]    = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  logic [7:0] kv_secret[8]  = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};

  // Plain software RC4 on the current key table.
  function automatic void build_exp(input int len, input int n);
    int s[256];
    int a, b, tmp, l;
    l = (len == 0) ? 256 : len;
    exp_q.delete();
    for (int x = 0; x < 256; x++) s[x] = x;
    b = 0;
    for (int x = 0; x < 256; x++) begin
      b = (b + s[x] + int'(key[x % l])) % 256;
      tmp = s[x]; s[x] = s[b]; s[b] = tmp;
    end
    a = 0; b = 0;
    for (int k = 0; k < n; k++) begin
      a = (a + 1) % 256;
      b = (b + s[a]) % 256;
      tmp = s[a]; s[a] = s[b]; s[b] = tmp;
      exp_q.push_back(8'(s[(s[a] + s[b]) % 256]));
    end
  endfunction

  function automatic logic [60:0] outs();
    return {busy, key_ready, ks_if.ks_valid, ks_if.ks_data, wen_2, wen_3,
            raddr_1, waddr_2, addr_3, key_addr, wdata_2, wdata_3};
  endfunction

  task automatic set_key_str(input string s);
    for (int k = 0; k < s.len(); k++) key[k] = s[k];
  endtask

  task automatic rand_key();
    for (int k = 0; k < 256; k++) key[k] = 8'($urandom);
  endtask

  task automatic do_start(input logic [7:0] len);
    @(negedge clk);
    key_len = len;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic collect(input int n, input int rdy_pct);
    int budget;
    budget = 1200 + n * 60;
    got_q.delete();
    got_cyc.delete();
    while (got_q.size() < n && budget > 0) begin
      ks_if.ks_ready = ($urandom_range(99) < rdy_pct);
      if (ks_if.ks_valid && ks_if.ks_ready) begin
        got_q.push_back(ks_if.ks_data);
        got_cyc.push_back(cyc);
      end
      @(negedge clk);
      budget--;
    end
    ks_if.ks_ready = 1'b0;
    n_cmp++;
    if (got_q.size() != n) begin
      n_bad++;
      $display("FAIL collect_timeout: got %0d bytes, want %0d", got_q.size(), n);
    end
  endtask

  task automatic check_model(input string name);
    for (int k = 0; k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== exp_q[k]) begin
        n_bad++;
        $display("FAIL %s[%0d]: got %h want %h", name, k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; key_len = '0; ks_if.ks_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (outs() !== 61'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", outs());
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || wen_2 !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy %b wen_2 %b want 0 0", busy, wen_2);
    end
  endtask

  task automatic test_key_vector();
    set_key_str("Key");
    do_start(8'd3);
    collect(10, 100);
    for (int k = 0; k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== kv_key[k]) begin
        n_bad++;
        $display("FAIL key_vec[%0d]: got %h want %h", k, got_q[k], kv_key[k]);
      end
    end
    for (int k = 1; k < got_cyc.size(); k++) begin
      n_cmp++;
      if (got_cyc[k] - got_cyc[k-1] !== 5) begin
        n_bad++;
        $display("FAIL byte_rate[%0d]: got %0d cycles want 5", k, got_cyc[k] - got_cyc[k-1]);
      end
    end
    do_abort();
  endtask

  task automatic test_secret();
    set_key_str("Secret");
    do_start(8'd6);
    repeat (1023) @(negedge clk);
    n_cmp++;
    if (key_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL key_ready_early: key_ready %b busy %b want 0 1", key_ready, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (key_ready !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL key_ready_1024: key_ready %b busy %b want 1 1", key_ready, busy);
    end
    collect(8, 100);
    for (int k = 0; k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== kv_secret[k]) begin
        n_bad++;
        $display("FAIL secret_vec[%0d]: got %h want %h", k, got_q[k], kv_secret[k]);
      end
    end
    do_abort();
  endtask

  task automatic test_backpressure();
    int len, w;
    rand_key();
    len = $urandom_range(32, 1);
    build_exp(len, 12);
    do_start(8'(len));
    w = 0;
    while (!ks_if.ks_valid && w < 1500) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (ks_if.ks_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_reach_out: ks_valid %b want 1", ks_if.ks_valid);
    end
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if (ks_if.ks_valid !== 1'b1 || ks_if.ks_data !== exp_q[0] ||
          wen_2 !== 1'b0 || wen_3 !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL stall[%0d]: valid %b data %h wen %b%b busy %b want 1 %h 00 0",
                 k, ks_if.ks_valid, ks_if.ks_data, wen_2, wen_3, busy, exp_q[0]);
      end
      @(negedge clk);
    end
    collect(12, 50);
    check_model("stall_stream");
    do_abort();
  endtask

  task automatic test_i_eq_j();
    int len;
    rand_key();
    key[0] = 8'h00;
    len = $urandom_range(16, 2);
    build_exp(len, 16);
    do_start(8'(len));
    repeat (258) @(negedge clk);
    n_cmp++;
    if (wen_2 !== 1'b1 || wen_3 !== 1'b0 || waddr_2 !== 8'd0 || addr_3 !== 8'd0) begin
      n_bad++;
      $display("FAIL i_eq_j_swap: wen_2 %b wen_3 %b waddr_2 %h addr_3 %h want 1 0 00 00",
               wen_2, wen_3, waddr_2, addr_3);
    end
    collect(16, 70);
    check_model("i_eq_j_stream");
    do_abort();
  endtask

  task automatic test_abort();
    set_key_str("Key");
    do_start(8'd3);
    repeat (288) @(negedge clk);
    n_cmp++;
    if (wen_2 !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_in_swap: wen_2 %b want 1", wen_2);
    end
    abort = 1'b1;
    #1;
    n_cmp++;
    if (wen_2 !== 1'b0 || wen_3 !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_write: wen_2 %b wen_3 %b want 0 0", wen_2, wen_3);
    end
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || key_ready !== 1'b0 || ks_if.ks_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: busy %b key_ready %b valid %b want 0 0 0",
               busy, key_ready, ks_if.ks_valid);
    end
    do_start(8'd3);
    collect(10, 100);
    for (int k = 0; k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== kv_key[k]) begin
        n_bad++;
        $display("FAIL abort_restart[%0d]: got %h want %h", k, got_q[k], kv_key[k]);
      end
    end
    do_abort();
  endtask

  task automatic test_reset_prga();
    int len;
    rand_key();
    len = $urandom_range(255, 1);
    do_start(8'(len));
    collect(5, 100);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs() !== 61'd0) begin
      n_bad++;
      $display("FAIL reset_in_prga: got %h want 0", outs());
    end
    rand_key();
    len = $urandom_range(40, 1);
    build_exp(len, 10);
    rst_n   = 1'b1;
    key_len = 8'(len);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL start_after_reset: busy %b want 1", busy);
    end
    collect(10, 80);
    check_model("post_reset_stream");
    do_abort();
  endtask

  task automatic test_random();
    int lens[5];
    int len;
    lens = '{1, 0, 255, int'($urandom_range(254, 2)), int'($urandom_range(254, 2))};
    for (int it = 0; it < 5; it++) begin
      rand_key();
      len = lens[it];
      build_exp(len, 16);
      do_start(8'(len));
      // A second start during key setup must be ignored, with a different length.
      repeat ($urandom_range(900, 5)) @(negedge clk);
      key_len = 8'(len) ^ 8'h5A;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      collect(16, $urandom_range(100, 20));
      check_model($sformatf("random%0d_len%0d", it, len));
      do_abort();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_key_vector();
    test_secret();
    test_backpressure();
    test_i_eq_j();
    test_abort();
    test_reset_prga();
    test_random();
    n_cmp++;
    if (collisions !== 0) begin
      n_bad++;
      $display("FAIL same_addr_double_write: got %0d cycles want 0", collisions);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
